apb_sram_slave: RTL and testbench
=================================

// Module: apb_sram_slave
// PURPOSE
//  APB4 memory-mapped SRAM slave, successor to the single-cycle APB register memory.
//  Adds configurable data width and depth, byte strobes, programmable wait states (PREADY),
//  a registered read path and PSLVERR on bad accesses.
//  Sits on the APB peripheral bus as a host-visible scratch/weight buffer for the TPU datapath.
// PARAMETERS
//  DATA_W       32   data bus width in bits; must be 32 or 64
//  ADDR_W       32   PADDR width in bits
//  DEPTH        256  number of DATA_W-bit words; must be a power of two
//  WAIT_CYCLES  1    PREADY-low cycles inserted in each ACCESS phase, 0..15
//  RO_WORDS     0    words [0, RO_WORDS) are read-only; writes to them error
// PORTS
//  i_clk      in   1         clock, all logic on posedge
//  i_rstn     in   1         synchronous reset, active-low
//  i_paddr    in   ADDR_W    byte address
//  i_psel     in   1         slave select
//  i_penable  in   1         access phase
//  i_pwrite   in   1         1 = write, 0 = read
//  i_pwdata   in   DATA_W    write data
//  i_pstrb    in   DATA_W/8  byte-lane write strobes
//  o_pready   out  1         transfer complete
//  o_prdata   out  DATA_W    read data; valid only when o_pready=1 on a read
//  o_pslverr  out  1         error response; valid only when o_pready=1
// BEHAVIOUR
//  - Reset (i_rstn=0 at posedge): FSM -> IDLE, wait counter=0, o_pready=0, o_prdata=0,
//    o_pslverr=0. Memory contents are not reset.
//  - FSM states:
//    - IDLE: on psel & !penable (setup), latch addr, write, wdata and strb; load
//      cnt=WAIT_CYCLES; go to ACCESS.
//    - ACCESS: if !psel, abort to IDLE with no write (protocol violation, no response).
//      If cnt!=0, decrement and hold o_pready=0. If cnt==0, go to RESP.
//    - RESP: o_pready=1 for exactly one cycle with o_prdata/o_pslverr valid; then IDLE.
//  - Outputs are registered. o_pready, o_prdata and o_pslverr are 0 in every cycle except RESP.
//  - Latency: setup edge -> o_pready high is WAIT_CYCLES+2 cycles.
//  - Back-to-back transfers are spaced by APB's mandatory setup phase; no pipelining.
//  - Word index = addr >> log2(DATA_W/8).
//  - Error (PSLVERR=1, no memory write, o_prdata=0), if any of:
//    - addr low bits != 0 (misaligned)
//    - index >= DEPTH
//    - write with index < RO_WORDS
//  - Write: committed on the ACCESS->RESP edge; only lanes with strb[i]=1 update.
//    pstrb=0 is legal: no change, no error.
//  - Read: memory read on the ACCESS->RESP edge and registered into o_prdata.
//  - Read-after-write to the same word in consecutive transfers returns the new data.
//  - Latched addr, write and strb are used throughout; changes on the bus during ACCESS are ignored.
//  - Reset mid-transfer: the transfer is dropped, no write occurs, FSM -> IDLE next cycle.
// STRUCTURE
//  - Package apb_pkg: state enum {IDLE, ACCESS, RESP}, localparam STRB_W=DATA_W/8,
//    localparam IDX_LSB=$clog2(STRB_W), and function is_err(addr, write).
//  - Sub-module apb_byte_ram (DEPTH x DATA_W):
//    - synchronous write with per-byte enable
//    - synchronous read
//    - no reset
//  - Top level holds the FSM, wait counter, error decode and output registers.
// TESTING
//  1. Reset, then write 0xDEADBEEF @0x10 (strb=0xF), read 0x10.
//     -> o_prdata=0xDEADBEEF, pslverr=0, pready exactly 1 cycle at setup+3.
//  2. Write 0x11223344 @0x20, then write 0xAABBCCDD @0x20 with strb=0x5, read 0x20.
//     -> 0x11BB33DD.
//  3. Read 0x400 (index 256, DEPTH=256) and read 0x02 (misaligned).
//     -> pslverr=1, prdata=0; a following read of 0x0 returns its prior value unchanged.
//  4. RO_WORDS=4: write 0x55 @0x08 -> pslverr=1, mem[2] unchanged; write @0x10 -> pslverr=0.
//  5. WAIT_CYCLES=0 and WAIT_CYCLES=3: measure setup -> pready.
//     -> 2 and 5 cycles; drop psel in ACCESS -> no write, no pready.
//  6. Assert i_rstn=0 during ACCESS of a write.
//     -> o_pready=0, target word unchanged, next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB SRAM slave: FSM state encoding and
// the access-legality decode used by the top level.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Flags misaligned addresses, out-of-range indices and writes into the
    // read-only window. Arguments are widened to 64 bits so one helper serves
    // every ADDR_W / DEPTH combination.
    function automatic logic is_err(
        input logic [63:0] addr,
        input logic        write,
        input int unsigned idx_lsb,
        input logic [63:0] depth,
        input logic [63:0] ro_words
    );
        logic [63:0] lsb_mask;
        logic [63:0] idx;
        lsb_mask = (64'd1 << idx_lsb) - 64'd1;
        idx      = addr >> idx_lsb;
        return ((addr & lsb_mask) != 64'd0) || (idx >= depth) || (write && (idx < ro_words));
    endfunction

endpackage

// File: rtl/apb_byte_ram.sv
// DEPTH x DATA_W single-port RAM built from independent byte lanes so each
// lane maps onto its own block RAM with a plain write enable.
module apb_byte_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [DATA_W/8-1:0]        i_be,
    input  logic                       i_re,
    input  logic [$clog2(DEPTH)-1:0]   i_idx,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata
);

    localparam int STRB_W = DATA_W / 8;

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rdata_reg;

        // Per-lane write with byte enable, registered read; no reset on storage.
        always_ff @(posedge i_clk) begin
            if (i_we && i_be[gi]) begin
                lane_mem[i_idx] <= i_wdata[gi*8 +: 8];
            end
            if (i_re) begin
                rdata_reg <= lane_mem[i_idx];
            end
        end

        assign o_rdata[gi*8 +: 8] = rdata_reg;
    end

endmodule

// File: rtl/apb_sram_slave.sv
// APB4 SRAM slave: latches the request in the setup phase, inserts
// WAIT_CYCLES of PREADY-low, commits/reads memory on the ACCESS->RESP edge
// and presents a one-cycle registered response.
module apb_sram_slave
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int RO_WORDS    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [ADDR_W-1:0]     i_paddr,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [DATA_W-1:0]     i_pwdata,
    input  logic [DATA_W/8-1:0]   i_pstrb,
    output logic                  o_pready,
    output logic [DATA_W-1:0]     o_prdata,
    output logic                  o_pslverr
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int IDX_LSB = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(DEPTH);

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                write_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   strb_reg;
    logic                err_reg;

    logic                req_err;
    logic                access_done;
    logic                ram_we;
    logic [IDX_W-1:0]    ram_idx;
    logic [DATA_W-1:0]   ram_rdata;

    // Everything downstream of the setup phase uses the latched request only.
    assign ram_idx     = addr_reg[IDX_LSB +: IDX_W];
    assign req_err     = is_err(64'(addr_reg), write_reg, IDX_LSB, 64'(DEPTH), 64'(RO_WORDS));
    assign access_done = (state_reg == ACCESS) && i_psel && (cnt_reg == 4'd0);
    // Gated by reset so a transfer caught by reset never reaches memory.
    assign ram_we      = i_rstn && access_done && write_reg && !req_err;

    apb_byte_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_be    (strb_reg),
        .i_re    (access_done),
        .i_idx   (ram_idx),
        .i_wdata (wdata_reg),
        .o_rdata (ram_rdata)
    );

    // Transfer FSM with wait counter and registered response outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            err_reg   <= 1'b0;
            o_pready  <= 1'b0;
            o_prdata  <= '0;
            o_pslverr <= 1'b0;
        end else begin
            o_pready  <= 1'b0;
            o_prdata  <= '0;
            o_pslverr <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_psel && !i_penable) begin
                        addr_reg  <= i_paddr;
                        write_reg <= i_pwrite;
                        wdata_reg <= i_pwdata;
                        strb_reg  <= i_pstrb;
                        cnt_reg   <= 4'(WAIT_CYCLES);
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!i_psel) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        err_reg   <= req_err;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    o_pready  <= 1'b1;
                    o_pslverr <= err_reg;
                    o_prdata  <= (err_reg || write_reg) ? '0 : ram_rdata;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_sram_slave.sv
// Directed bench for apb_sram_slave: three instances cover WAIT_CYCLES=1 with
// a read-only window, WAIT_CYCLES=0 and WAIT_CYCLES=3.
module tb_apb_sram_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] paddr;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic        pready_v  [3];
    logic [31:0] prdata_v  [3];
    logic        pslverr_v [3];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(1), .RO_WORDS(4)) u_dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_paddr(paddr), .i_psel(psel[0]), .i_penable(penable),
        .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
        .o_pready(pready_v[0]), .o_prdata(prdata_v[0]), .o_pslverr(pslverr_v[0])
    );

    apb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0), .RO_WORDS(0)) u_dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_paddr(paddr), .i_psel(psel[1]), .i_penable(penable),
        .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
        .o_pready(pready_v[1]), .o_prdata(prdata_v[1]), .o_pslverr(pslverr_v[1])
    );

    apb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3), .RO_WORDS(0)) u_dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_paddr(paddr), .i_psel(psel[2]), .i_penable(penable),
        .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
        .o_pready(pready_v[2]), .o_prdata(prdata_v[2]), .o_pslverr(pslverr_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete APB transfer on instance d; also checks PREADY lasts one cycle.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
        psel[d] = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = -1; rd = '0; er = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (pready_v[d]) begin
                lat = c; rd = prdata_v[d]; er = pslverr_v[d];
                break;
            end
        end
        psel[d] = 1'b0; penable = 1'b0;
        $display("[TB] dut%0d %s addr=0x%08h wdata=0x%08h strb=0x%0h rdata=0x%08h err=%0d lat=%0d",
                 d, wr ? "WR" : "RD", addr, wd, st, rd, er, lat);
        @(posedge clk); #1;
        check("pready_one_cycle", 64'(pready_v[d]), 64'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        seen;

    initial begin
        rstn = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready",  64'(pready_v[0]),  64'd0);
        check("rst_prdata",  64'(prdata_v[0]),  64'd0);
        check("rst_pslverr", 64'(pslverr_v[0]), 64'd0);
        rstn = 1'b1;

        // Basic write/read, latency WAIT_CYCLES+2 = 3
        xfer(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("t1_wr_err", 64'(er), 64'd0);
        check("t1_wr_lat", 64'(lat), 64'd3);
        xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        check("t1_rd_data", 64'(rd), 64'hDEADBEEF);
        check("t1_rd_err", 64'(er), 64'd0);
        check("t1_rd_lat", 64'(lat), 64'd3);

        // Byte strobes: lanes 0 and 2 updated
        xfer(0, 32'h20, 1'b1, 32'h11223344, 4'hF, rd, er, lat);
        xfer(0, 32'h20, 1'b1, 32'hAABBCCDD, 4'h5, rd, er, lat);
        check("t2_wr_err", 64'(er), 64'd0);
        xfer(0, 32'h20, 1'b1, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        check("t2_strb0_err", 64'(er), 64'd0);
        xfer(0, 32'h20, 1'b0, 32'h0, 4'h0, rd, er, lat);
        check("t2_rd_data", 64'(rd), 64'h11BB33DD);

        // Out-of-range and misaligned accesses on the zero-wait instance
        xfer(1, 32'h0, 1'b1, 32'hCAFEF00D, 4'hF, rd, er, lat);
        check("t5_lat_w0", 64'(lat), 64'd2);
        xfer(1, 32'h2, 1'b1, 32'h00000000, 4'hF, rd, er, lat);
        check("t3_misal_wr_err", 64'(er), 64'd1);
        xfer(1, 32'h400, 1'b0, 32'h0, 4'h0, rd, er, lat);
        check("t3_oor_err", 64'(er), 64'd1);
        check("t3_oor_data", 64'(rd), 64'd0);
        xfer(1, 32'h2, 1'b0, 32'h0, 4'h0, rd, er, lat);
        check("t3_misal_err", 64'(er), 64'd1);
        check("t3_misal_data", 64'(rd), 64'd0);
        xfer(1, 32'h0, 1'b0, 32'h0, 4'h0, rd, er, lat);
        check("t3_word0_data", 64'(rd), 64'hCAFEF00D);
        check("t3_word0_err", 64'(er), 64'd0);

        // Read-only window: words 0..3
        xfer(0, 32'h08, 1'b1, 32'h00000055, 4'hF, rd, er, lat);
        check("t4_ro_wr_err", 64'(er), 64'd1);
        xfer(0, 32'h0C, 1'b1, 32'h00000055, 4'hF, rd, er, lat);
        check("t4_ro_last_err", 64'(er), 64'd1);
        xfer(0, 32'h10, 1'b1, 32'h00000077, 4'hF, rd, er, lat);
        check("t4_rw_first_err", 64'(er), 64'd0);
        xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, rd, er, lat);
        check("t4_ro_rd_err", 64'(er), 64'd0);
        check("t4_ro_not_written", 64'(rd == 32'h55), 64'd0);
        xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        check("t4_rw_data", 64'(rd), 64'h77);

        // Three wait states, then an aborted write
        xfer(2, 32'h40, 1'b1, 32'h12345678, 4'hF, rd, er, lat);
        check("t5_lat_w3", 64'(lat), 64'd5);
        @(posedge clk); #1;
        paddr = 32'h40; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        psel[2] = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel[2] = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (pready_v[2]) seen = 1'b1;
        end
        $display("[TB] dut2 ABORT addr=0x00000040 pready_seen=%0d", seen);
        check("t5_abort_no_pready", 64'(seen), 64'd0);
        xfer(2, 32'h40, 1'b0, 32'h0, 4'h0, rd, er, lat);
        check("t5_abort_no_write", 64'(rd), 64'h12345678);

        // Reset during ACCESS of a write on the zero-wait instance
        xfer(1, 32'h44, 1'b1, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        @(posedge clk); #1;
        paddr = 32'h44; pwrite = 1'b1; pwdata = 32'h00000000; pstrb = 4'hF;
        psel[1] = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; rstn = 1'b0;
        @(posedge clk); #1;
        $display("[TB] dut1 RESET-IN-ACCESS addr=0x00000044 pready=%0d", pready_v[1]);
        check("t6_rst_pready", 64'(pready_v[1]), 64'd0);
        rstn = 1'b1; psel[1] = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_pready_after", 64'(pready_v[1]), 64'd0);
        xfer(1, 32'h44, 1'b0, 32'h0, 4'h0, rd, er, lat);
        check("t6_word_unchanged", 64'(rd), 64'hA5A5A5A5);
        check("t6_next_lat", 64'(lat), 64'd2);
        check("t6_next_err", 64'(er), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
